// File: rtl/min_max_pkg.sv
// Constants shared by the min/max loader, finder and wrapper.
package min_max_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned SUM_W = WIDTH + AW;

    // One-hot control states; bit order matches {Qw,Qs,Qf,Qi}.
    typedef enum logic [3:0] {
        INI  = 4'b0001,
        FILL = 4'b0010,
        STRT = 4'b0100,
        WAIT = 4'b1000
    } state_e;

endpackage

// File: rtl/min_max_regfile.sv
// DEPTH x WIDTH array: synchronous write, combinational read, no reset.
module min_max_regfile
    import min_max_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] rd
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wa] <= wd;
        end
    end

    assign rd = mem_q[ra];

endmodule

// File: rtl/min_max_array_loader.sv
// Packs 16 streamed bytes into the finder's array, pulses Start, then freezes until Done_In.
// Optional running byte sum on output Sum when LOADER_SUM_EN is defined.
module min_max_array_loader
    import min_max_pkg::*;
(
    input  logic             Clk,
    input  logic             Resetb,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [AW-1:0]    Rd_Addr,
    output logic [WIDTH-1:0] Rd_Data,
    output logic             Start,
    input  logic             Done_In,
    output logic [AW-1:0]    Wr_Ptr,
    output logic             Qi,
    output logic             Qf,
    output logic             Qs,
    output logic             Qw
`ifdef LOADER_SUM_EN
    ,
    output logic [SUM_W-1:0] Sum
`endif
);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          start_q;
    logic          in_ready_q;
    logic          xfer_c;
    logic          we_c;

    assign xfer_c = In_Valid & in_ready_q;

    // Next-state and write-enable decode
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        we_c     = 1'b0;
        unique case (state_q)
            INI: begin
                wr_ptr_d = '0;
                state_d  = FILL;
            end
            FILL: begin
                if (xfer_c) begin
                    we_c     = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (wr_ptr_q == AW'(DEPTH - 1)) begin
                        state_d = STRT;
                    end
                end
            end
            STRT: state_d = WAIT;
            WAIT: begin
                if (Done_In) begin
                    state_d = INI;
                end
            end
            default: state_d = INI;
        endcase
    end

    // Start and In_Ready are flopped from the next state so they track state_q exactly
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            state_q    <= INI;
            wr_ptr_q   <= '0;
            start_q    <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            start_q    <= (state_d == STRT);
            in_ready_q <= (state_d == FILL);
        end
    end

    min_max_regfile u_regfile (
        .clk (Clk),
        .we  (we_c),
        .wa  (wr_ptr_q),
        .wd  (In_Data),
        .ra  (Rd_Addr),
        .rd  (Rd_Data)
    );

`ifdef LOADER_SUM_EN
    logic [SUM_W-1:0] sum_q, sum_d;

    // Sum reads zero from the moment INI is entered until the next frame's first transfer
    always_comb begin
        sum_d = sum_q;
        if ((state_q == INI) || (state_d == INI)) begin
            sum_d = '0;
        end else if (we_c) begin
            sum_d = sum_q + SUM_W'(In_Data);
        end
    end

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign Sum = sum_q;
`endif

    assign In_Ready         = in_ready_q;
    assign Start            = start_q;
    assign Wr_Ptr           = wr_ptr_q;
    assign {Qw, Qs, Qf, Qi} = state_q;

endmodule

// File: tb/tb_min_max_array_loader.sv
// Randomized bench for min_max_array_loader against a phase/count model of the loader.
module tb_min_max_array_loader;
    import min_max_pkg::*;

    logic             Clk      = 1'b0;
    logic             Resetb   = 1'b1;
    logic [WIDTH-1:0] In_Data  = '0;
    logic             In_Valid = 1'b0;
    logic             In_Ready;
    logic [AW-1:0]    Rd_Addr  = '0;
    logic [WIDTH-1:0] Rd_Data;
    logic             Start;
    logic             Done_In  = 1'b0;
    logic [AW-1:0]    Wr_Ptr;
    logic             Qi, Qf, Qs, Qw;
`ifdef LOADER_SUM_EN
    logic [SUM_W-1:0] Sum;
`endif

    always #5 Clk = ~Clk;

    min_max_array_loader dut (
        .Clk      (Clk),
        .Resetb   (Resetb),
        .In_Data  (In_Data),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .Rd_Addr  (Rd_Addr),
        .Rd_Data  (Rd_Data),
        .Start    (Start),
        .Done_In  (Done_In),
        .Wr_Ptr   (Wr_Ptr),
        .Qi       (Qi),
        .Qf       (Qf),
        .Qs       (Qs),
        .Qw       (Qw)
`ifdef LOADER_SUM_EN
        ,
        .Sum      (Sum)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_starts = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: phase 0=INI 1=FILL 2=STRT 3=WAIT, count of bytes taken in this frame
    int         m_phase  = 0;
    int         m_cnt    = 0;
    int         m_sum    = 0;
    int         m_frames = 0;
    logic [7:0] m_mem [16];
    bit         m_known [16];

    initial begin
        forever begin
            @(posedge Clk or negedge Resetb);
            if (!Resetb) begin
                m_phase = 0;
                m_cnt   = 0;
                m_sum   = 0;
            end else begin
                case (m_phase)
                    0: begin m_phase = 1; m_cnt = 0; m_sum = 0; end
                    1: if (In_Valid) begin
                        m_mem[m_cnt]   = In_Data;
                        m_known[m_cnt] = 1'b1;
                        m_sum          = m_sum + int'(In_Data);
                        m_cnt++;
                        if (m_cnt == 16) begin
                            m_phase = 2;
                            m_cnt   = 0;
                            m_frames++;
                        end
                    end
                    2: m_phase = 3;
                    default: if (Done_In) begin m_phase = 0; m_sum = 0; end
                endcase
            end
        end
    end

    // Per-cycle comparison on the falling edge
    initial begin
        forever begin
            @(negedge Clk);
            if (Start) n_starts++;
            if (cmp_en) begin
                check("in_ready", 32'(In_Ready), 32'(m_phase == 1));
                check("start", 32'(Start), 32'(m_phase == 2));
                check("state", 32'({Qw, Qs, Qf, Qi}), 32'(1 << m_phase));
                check("wr_ptr", 32'(Wr_Ptr), (m_phase == 1) ? 32'(m_cnt) : 32'd0);
                if (m_known[Rd_Addr]) check("rd_data", 32'(Rd_Data), 32'(m_mem[Rd_Addr]));
`ifdef LOADER_SUM_EN
                check("sum", 32'(Sum), 32'(m_sum));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Offer one byte and return after the edge that accepts it
    task automatic send(input logic [7:0] d);
        bit r;
        bit ok;
        ok       = 1'b0;
        In_Valid = 1'b1;
        In_Data  = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge Clk);
            r = In_Ready;
            @(posedge Clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic done_pulse();
        Done_In = 1'b1;
        tick();
        Done_In = 1'b0;
    endtask

    int exp_frames = 0;
    int starts_before;

    initial begin
        #2;
        Resetb = 1'b0;
        #1;
        cmp_en = 1'b1;
        check("rst_state", 32'({Qw, Qs, Qf, Qi}), 32'h1);
        check("rst_ready", 32'(In_Ready), 32'd0);
        check("rst_start", 32'(Start), 32'd0);
        check("rst_ptr", 32'(Wr_Ptr), 32'd0);
        tick();
        tick();
        Resetb = 1'b1;

        // Continuous stream 0x10..0x1F
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
        In_Valid = 1'b0;
        exp_frames++;
        check("start_after_16th", 32'(Start), 32'd1);
        Rd_Addr = 4'd5;
        #1;
        check("rd_addr5", 32'(Rd_Data), 32'h15);
        tick();
        check("start_one_cycle", 32'(Start), 32'd0);
        check("wait_entered", 32'(Qw), 32'd1);

        // Frozen while waiting despite offered data
        In_Valid = 1'b1;
        In_Data  = 8'hFF;
        for (int i = 0; i < 10; i++) tick();
        check("wait_not_ready", 32'(In_Ready), 32'd0);
        Rd_Addr = 4'd0;
        #1;
        check("frozen_addr0", 32'(Rd_Data), 32'h10);
        In_Valid = 1'b0;
        done_pulse();
        check("ini_after_done", 32'(Qi), 32'd1);
        tick();
        check("fill_after_ini", 32'({Qf, In_Ready}), 32'd3);

        // Toggling valid stream 0x20..0x2F
        for (int i = 0; i < 16; i++) begin
            send(8'(8'h20 + i));
            In_Valid = 1'b0;
            if (i < 15) begin
                tick();
                check("ptr_hold", 32'(Wr_Ptr), 32'(i + 1));
            end
        end
        exp_frames++;
        check("start_toggle", 32'(Start), 32'd1);
        tick();
        done_pulse();

        // Reset after the 7th transfer
        for (int i = 0; i < 7; i++) send(8'(8'h30 + i));
        In_Valid = 1'b0;
        check("ptr_at_7", 32'(Wr_Ptr), 32'd7);
        starts_before = n_starts;
        #1;
        Resetb = 1'b0;
        #1;
        check("async_ini", 32'({Qw, Qs, Qf, Qi}), 32'h1);
        check("async_ptr", 32'(Wr_Ptr), 32'd0);
        tick();
        Resetb = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i));
        In_Valid = 1'b0;
        exp_frames++;
        check("no_start_partial", 32'(n_starts), 32'(starts_before));
        Rd_Addr = 4'd15;
        #1;
        check("fresh_addr15", 32'(Rd_Data), 32'h4F);
        tick();
        check("fresh_wait", 32'(Qw), 32'd1);

        // Done_In held through INI, FILL and STRT
        Done_In = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send(8'(8'h50 + i));
        In_Valid = 1'b0;
        exp_frames++;
        check("held_strt", 32'(Qs), 32'd1);
        tick();
        check("held_wait", 32'(Qw), 32'd1);
        tick();
        check("held_exit", 32'(Qi), 32'd1);
        Done_In = 1'b0;

        // Randomized frames with stalls, random reads and random wait length
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 16; i++) begin
                while ($urandom_range(0, 2) == 0) begin
                    In_Valid = 1'b0;
                    In_Data  = 8'($urandom);
                    Rd_Addr  = 4'($urandom);
                    tick();
                end
                Rd_Addr = 4'($urandom);
                send(8'($urandom));
            end
            exp_frames++;
            for (int w = 0; w < int'($urandom_range(1, 8)); w++) begin
                In_Valid = 1'($urandom);
                In_Data  = 8'($urandom);
                Rd_Addr  = 4'($urandom);
                tick();
            end
            In_Valid = 1'b0;
            done_pulse();
        end

`ifdef LOADER_SUM_EN
        for (int i = 0; i < 16; i++) send(8'hFF);
        In_Valid = 1'b0;
        exp_frames++;
        tick();
        check("sum_wait", 32'(Sum), 32'hFF0);
        done_pulse();
        check("sum_cleared", 32'(Sum), 32'd0);
`endif

        tick();
        tick();
        check("start_count", 32'(n_starts), 32'(exp_frames));
        check("model_frames", 32'(m_frames), 32'(exp_frames));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/min_max_array_loader.md
Name: min_max_array_loader

Overview:
- Upstream feeder for the min/max finder datapath.
- Accepts a byte stream over a valid/ready handshake and packs 16 consecutive bytes into an internal 16x8 array.
- Exposes the array through a combinational read port that the finder indexes with its I counter.
- Pulses Start to the finder, then freezes the array until the finder reports DONE.

Parameters:
- WIDTH, 8, element width in bits.
- DEPTH, 16, elements per array; must be a power of 2.
- AW, 4, address width; equals log2(DEPTH).

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Resetb  input  1  asynchronous, active-low reset.
- In_Data  input  WIDTH  incoming element.
- In_Valid  input  1  In_Data is valid this cycle.
- In_Ready  output  1  loader accepts In_Data this cycle.
- Rd_Addr  input  AW  read index from the finder.
- Rd_Data  output  WIDTH  M[Rd_Addr]; combinational.
- Start  output  1  one-cycle pulse to the finder.
- Done_In  input  1  finder DONE-state flag (its Qd).
- Wr_Ptr  output  AW  next write index; observability.
- Qi, Qf, Qs, Qw  output  1 each  one-hot state bits for INI, FILL, STRT, WAIT.

Behaviour:
- State encoding, one-hot: INI=4'b0001, FILL=4'b0010, STRT=4'b0100, WAIT=4'b1000. {Qw,Qs,Qf,Qi}=state.
- Reset (Resetb=0, asynchronous):
  - state=INI, Wr_Ptr=0, Start=0, In_Ready=0.
  - Array contents are not reset; they read as X until written.
- A transfer happens only on a rising edge with In_Valid=1 and In_Ready=1. In_Data is ignored otherwise.
- INI:
  - In_Ready=0. Wr_Ptr<=0.
  - Moves unconditionally to FILL on the next edge.
- FILL:
  - In_Ready=1.
  - On a transfer: M[Wr_Ptr]<=In_Data; Wr_Ptr<=Wr_Ptr+1 (AW-bit wrap).
  - On a transfer with Wr_Ptr==DEPTH-1: state<=STRT; Wr_Ptr wraps to 0.
  - In_Valid stalls of any length are allowed; Wr_Ptr holds while stalled.
- STRT:
  - Start=1 for exactly this one cycle. In_Ready=0.
  - Moves unconditionally to WAIT.
  - Done_In is ignored in this state.
- WAIT:
  - In_Ready=0. Array and Wr_Ptr are frozen.
  - On Done_In=1: state<=INI.
  - Minimum turnaround from the last transfer to the next accepted byte is 1 (STRT) + cycles in WAIT + 1 (INI).
- Start is registered-state decoded: Start = (state==STRT), with no combinational path from any input.
- Rd_Data = M[Rd_Addr] in every state. A read during FILL of the address being written returns the old value; the new value appears after the edge.
- Reset asserted mid-FILL or mid-WAIT:
  - Returns to INI and discards the partial array.
  - No Start is issued for a partial array.
- Done_In held high across many cycles: only the first sampled cycle in WAIT causes the transition. Done_In in INI or FILL has no effect.

Optional Feature:
- Macro: LOADER_SUM_EN.
- Defined:
  - Adds output Sum, width WIDTH+AW (12 bits by default).
  - Cleared to 0 in INI and on reset.
  - Sum<=Sum+In_Data on every transfer in FILL.
  - Holds through STRT and WAIT, so it carries the full 16-element sum while the finder runs.
- Undefined: no Sum port and no adder. All other behaviour is identical.

Decomposition:
- Shared package min_max_pkg:
  - State localparams INI/FILL/STRT/WAIT.
  - WIDTH, DEPTH and AW defaults.
  - These constants are reused by the finder and the top-level wrapper.
- One natural sub-module: min_max_regfile.
  - 16xWIDTH array, synchronous write (we, wa, wd), combinational read (ra, rd).
  - No reset.
- FSM, pointer and optional Sum stay in the loader.

Test Plan:
- Reset then stream bytes 0x10..0x1F with In_Valid=1 continuously:
  - 16 transfers.
  - Start high exactly one cycle, one cycle after the 16th transfer.
  - Rd_Addr=5 returns 0x15.
- Same stream with In_Valid toggling 1/0 each cycle:
  - Still exactly 16 writes; Wr_Ptr holds during low cycles.
  - Start appears one cycle after the 16th transfer.
- After Start, hold In_Valid=1 with 0xFF for 10 cycles, Done_In=0:
  - In_Ready=0 throughout; array is unchanged (Rd_Addr=0 returns 0x10).
  - Raise Done_In for one cycle: INI, then FILL, In_Ready=1.
- Assert Resetb=0 after the 7th transfer:
  - state=INI and Wr_Ptr=0 immediately, without waiting for a clock edge.
  - No Start pulse.
  - A fresh 16-byte stream completes normally.
- Done_In=1 held during FILL and STRT: no early exit; WAIT is still entered, then left on the first cycle there.
- With LOADER_SUM_EN defined, stream 16 x 0xFF: Sum=0xFF0 in WAIT; cleared to 0 after returning to INI.
